mem_responder: RTL

Memory-side responder for the multicycle CPU's memory interface. It accepts single-word fetch, load and store requests from the control path and datapath. It services them against a synchronous single-port RAM with a fixed read latency, or against a small memory-mapped I/O window. It returns data with a one-cycle `ack` pulse. It sits between the CPU core and the RAM macro/IO pins and owns all memory wait-state sequencing.

---
 rtl/mem_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: sequences single-word fetch/load/store requests against a
// fixed-latency synchronous RAM or a small memory-mapped IO window, acking each once.
module mem_responder #(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 16,
  parameter int                RD_LAT  = 2,
  parameter logic [ADDR_W-1:0] IO_BASE = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_IO, S_ACK} state_t;

  localparam logic [2:0]        LAST    = 3'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] IO_IN_A = IO_BASE + ADDR_W'(1);

  state_t            state, state_d;
  logic [2:0]        cnt;
  logic              we_q, fetch_q, err_q;
  logic [DATA_W-1:0] sync1, sync2;
  logic              is_io, io_reg, io_in_reg;

  assign is_io     = (addr >= IO_BASE);
  assign io_reg    = (ram_addr == IO_BASE);
  assign io_in_reg = (ram_addr == IO_IN_A);

  assign busy   = (state != S_IDLE);
  assign ram_we = (state == S_WR);
  assign ack    = (state == S_ACK);
  assign err    = ack & err_q;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (req) begin
        if (is_io)             state_d = fetch ? S_ACK : S_IO;
        else if (fetch || !we) state_d = S_RD;
        else                   state_d = S_WR;
      end
      S_RD:   if (cnt == LAST) state_d = S_ACK;
      S_WR:   state_d = S_ACK;
      S_IO:   state_d = S_ACK;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      fetch_q   <= 1'b0;
      err_q     <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata     <= '0;
      instr     <= '0;
      io_out    <= '0;
      sync1     <= '0;
      sync2     <= '0;
    end else begin
      state <= state_d;
      sync1 <= io_in;
      sync2 <= sync1;
      case (state)
        S_IDLE: if (req) begin
          ram_addr  <= addr;
          ram_wdata <= wdata;
          we_q      <= we & ~fetch;
          fetch_q   <= fetch;
          cnt       <= '0;
          // Fetching from IO space is illegal and skips straight to ACK.
          err_q     <= is_io & fetch;
        end
        S_RD: begin
          cnt <= cnt + 3'd1;
          if (cnt == LAST) begin
            if (fetch_q) instr <= ram_rdata;
            else         rdata <= ram_rdata;
          end
        end
        S_IO: begin
          if (we_q) begin
            // Only io_out is writable; any other IO write just flags err.
            if (io_reg) io_out <= ram_wdata;
            else        err_q  <= 1'b1;
          end else begin
            rdata <= io_reg ? io_out : (io_in_reg ? sync2 : '0);
          end
        end
        S_ACK:   err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
